// File: rtl/reg_file_bank_pkg.sv
// Shared definitions for the register file bank: register-type codes,
// default widths and the mask-decode helper.
// Optional feature macro used by this slice: REG_BANK_SHADOW_EN.
package reg_file_bank_pkg;

    localparam logic [1:0] REG_RO  = 2'd0;
    localparam logic [1:0] REG_RW  = 2'd1;
    localparam logic [1:0] REG_W1C = 2'd2;

    localparam int unsigned DEF_ADDR_WIDTH = 4;
    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_NUM_REGS   = 16;

    // RW takes priority when a register is flagged in both masks
    function automatic logic [1:0] reg_type_decode(input logic rw_bit, input logic w1c_bit);
        if (rw_bit) begin
            return REG_RW;
        end
        if (w1c_bit) begin
            return REG_W1C;
        end
        return REG_RO;
    endfunction

endpackage

// File: rtl/reg_file_cell.sv
// Single register of the bank: byte-enable write, write-1-to-clear status
// and, when REG_BANK_SHADOW_EN is defined, a shadow copy committed on update.
module reg_file_cell
    import reg_file_bank_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [1:0]  REG_TYPE   = REG_RO
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_wr,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH-1:0]   i_hw,
    input  logic                    i_update,
    output logic [DATA_WIDTH-1:0]   o_active,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] w_bit_en;
    logic [DATA_WIDTH-1:0] w_clr;
    logic [DATA_WIDTH-1:0] r_active;
    logic [DATA_WIDTH-1:0] w_active_nxt;

    // Expand byte enables to a per-bit mask
    always_comb begin
        w_bit_en = '0;
        for (int unsigned b = 0; b < NUM_BYTES; b++) begin
            w_bit_en[b*8 +: 8] = {8{i_be[b]}};
        end
    end

    assign w_clr = i_wr ? (i_wdata & w_bit_en) : '0;

`ifdef REG_BANK_SHADOW_EN
    logic [DATA_WIDTH-1:0] r_shadow;
    logic [DATA_WIDTH-1:0] w_shadow_nxt;

    // Writes land in the shadow; update copies the post-write shadow to active
    always_comb begin
        w_shadow_nxt = r_shadow;
        w_active_nxt = r_active;
        case (REG_TYPE)
            REG_RW: begin
                if (i_wr) begin
                    w_shadow_nxt = (i_wdata & w_bit_en) | (r_shadow & ~w_bit_en);
                end
                if (i_update) begin
                    w_active_nxt = w_shadow_nxt;
                end
            end
            // Hardware set dominates a same-cycle software clear
            REG_W1C: w_active_nxt = (r_active & ~w_clr) | i_hw;
            default: w_active_nxt = '0;
        endcase
    end

    // Storage for shadow and active copies
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow <= '0;
            r_active <= '0;
        end else begin
            r_shadow <= w_shadow_nxt;
            r_active <= w_active_nxt;
        end
    end

    assign o_rdata = (REG_TYPE == REG_RW)  ? r_shadow :
                     (REG_TYPE == REG_W1C) ? r_active : i_hw;
`else
    logic w_unused_update;
    assign w_unused_update = i_update;

    // Writes go straight to the active copy
    always_comb begin
        w_active_nxt = r_active;
        case (REG_TYPE)
            REG_RW: begin
                if (i_wr) begin
                    w_active_nxt = (i_wdata & w_bit_en) | (r_active & ~w_bit_en);
                end
            end
            // Hardware set dominates a same-cycle software clear
            REG_W1C: w_active_nxt = (r_active & ~w_clr) | i_hw;
            default: w_active_nxt = '0;
        endcase
    end

    // Storage for the active copy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active <= '0;
        end else begin
            r_active <= w_active_nxt;
        end
    end

    assign o_rdata = (REG_TYPE == REG_RW || REG_TYPE == REG_W1C) ? r_active : i_hw;
`endif

    assign o_active = r_active;

endmodule

// File: rtl/reg_file_bank.sv
// Register file bank: NUM_REGS cells of RO/RW/W1C type selected by masks,
// a registered read mux and a one-cycle access acknowledge.
// Optional feature macro: REG_BANK_SHADOW_EN (double-buffered RW registers).
module reg_file_bank
    import reg_file_bank_pkg::*;
#(
    parameter int unsigned         ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned         DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned         NUM_REGS   = DEF_NUM_REGS,
    parameter logic [NUM_REGS-1:0] RW_MASK    = '0,
    parameter logic [NUM_REGS-1:0] W1C_MASK   = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic                           rd,
    input  logic                           wr,
    input  logic [DATA_WIDTH/8-1:0]        be,
    input  logic [ADDR_WIDTH-1:0]          addr,
    input  logic [DATA_WIDTH-1:0]          data_in,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic                           ack,
    input  logic [DATA_WIDTH*NUM_REGS-1:0] values_in,
    output logic [DATA_WIDTH*NUM_REGS-1:0] values_out,
    input  logic                           update
);

    logic                  w_accept;
    logic                  w_wr_acc;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic [DATA_WIDTH-1:0] w_cell_rdata [NUM_REGS];
    logic                  r_ack;
    logic [DATA_WIDTH-1:0] r_data_out;

    assign w_accept = en & (rd | wr);
    // A combined rd+wr strobe is treated as a pure read
    assign w_wr_acc = en & wr & ~rd;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        logic w_sel_wr;
        // Out-of-range addresses never match a cell, so such writes drop
        assign w_sel_wr = w_wr_acc & (addr == ADDR_WIDTH'(i));

        reg_file_cell #(
            .DATA_WIDTH (DATA_WIDTH),
            .REG_TYPE   (reg_type_decode(RW_MASK[i], W1C_MASK[i]))
        ) u_cell (
            .clk      (clk),
            .reset    (reset),
            .i_wr     (w_sel_wr),
            .i_be     (be),
            .i_wdata  (data_in),
            .i_hw     (values_in[i*DATA_WIDTH +: DATA_WIDTH]),
            .i_update (update),
            .o_active (values_out[i*DATA_WIDTH +: DATA_WIDTH]),
            .o_rdata  (w_cell_rdata[i])
        );
    end

    // Read mux; unmatched (out-of-range) addresses read as zero
    always_comb begin
        w_rdata = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (addr == ADDR_WIDTH'(i)) begin
                w_rdata = w_cell_rdata[i];
            end
        end
    end

    // Acknowledge pulse and read data capture, held until the next read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack      <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_ack <= w_accept;
            if (en && rd) begin
                r_data_out <= w_rdata;
            end
        end
    end

    assign ack      = r_ack;
    assign data_out = r_data_out;

endmodule

// File: tb/tb_reg_file_bank.sv
// Directed self-checking bench for reg_file_bank (NUM_REGS=8, 16-bit data).
// Regs 2,3,6 are RW (6 is also in the W1C mask), reg 5 is W1C, others RO.
module tb_reg_file_bank;

`ifdef REG_BANK_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic         en;
    logic         rd;
    logic         wr;
    logic [1:0]   be;
    logic [3:0]   addr;
    logic [15:0]  data_in;
    logic [15:0]  data_out;
    logic         ack;
    logic [127:0] values_in;
    logic [127:0] values_out;
    logic         update;

    int n_cmp = 0;
    int n_err = 0;

    reg_file_bank #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (16),
        .NUM_REGS   (8),
        .RW_MASK    (8'b0100_1100),
        .W1C_MASK   (8'b0110_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .rd         (rd),
        .wr         (wr),
        .be         (be),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .ack        (ack),
        .values_in  (values_in),
        .values_out (values_out),
        .update     (update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] slot(input logic [127:0] v, input int i);
        return v[i*16 +: 16];
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted access; returns in the ack cycle, 1 time unit after the edge
    task automatic acc(input logic a_rd, input logic a_wr, input logic [1:0] a_be,
                       input logic [3:0] a_addr, input logic [15:0] a_data);
        en      = 1'b1;
        rd      = a_rd;
        wr      = a_wr;
        be      = a_be;
        addr    = a_addr;
        data_in = a_data;
        tick();
        en = 1'b0;
        rd = 1'b0;
        wr = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        en        = 1'b0;
        rd        = 1'b0;
        wr        = 1'b0;
        be        = 2'b00;
        addr      = 4'd0;
        data_in   = 16'h0000;
        values_in = '0;
        update    = 1'b0;

        repeat (3) tick();
        chk("reset_ack", {15'd0, ack}, 16'h0001 & 16'h0000);
        chk("reset_dout", data_out, 16'h0000);
        chk("reset_slot3", slot(values_out, 3), 16'h0000);
        chk("reset_slot5", slot(values_out, 5), 16'h0000);
        reset = 1'b0;

        // Full write then read of RW register 3
        acc(1'b0, 1'b1, 2'b11, 4'd3, 16'hBEEF);
        chk("wr3_ack", {15'd0, ack}, 16'h0001);
        chk("wr3_slot", slot(values_out, 3), SHADOW ? 16'h0000 : 16'hBEEF);
        tick();
        chk("ack_pulse_low", {15'd0, ack}, 16'h0000);
        acc(1'b1, 1'b0, 2'b11, 4'd3, 16'h0000);
        chk("rd3_ack", {15'd0, ack}, 16'h0001);
        chk("rd3_data", data_out, 16'hBEEF);

        // Low-byte-only write; data_out must hold across a write
        acc(1'b0, 1'b1, 2'b01, 4'd3, 16'h1234);
        chk("dout_hold", data_out, 16'hBEEF);
        acc(1'b1, 1'b0, 2'b11, 4'd3, 16'h0000);
        chk("rd3_bytemask", data_out, 16'hBE34);

        // W1C register 5: hardware set, set-vs-clear collision, then clear
        values_in[5*16 +: 16] = 16'h0004;
        tick();
        values_in = '0;
        chk("w1c_set", slot(values_out, 5), 16'h0004);
        acc(1'b1, 1'b0, 2'b11, 4'd5, 16'h0000);
        chk("w1c_rd_set", data_out, 16'h0004);
        values_in[5*16 +: 16] = 16'h0004;
        acc(1'b0, 1'b1, 2'b11, 4'd5, 16'h0004);
        values_in = '0;
        chk("w1c_set_wins", slot(values_out, 5), 16'h0004);
        acc(1'b0, 1'b1, 2'b11, 4'd5, 16'h0004);
        chk("w1c_cleared", slot(values_out, 5), 16'h0000);
        acc(1'b1, 1'b0, 2'b11, 4'd5, 16'h0000);
        chk("w1c_rd_clear", data_out, 16'h0000);

        // RO register 1 reads values_in, ignores writes, shows 0 on values_out
        values_in[1*16 +: 16] = 16'hA5A5;
        acc(1'b1, 1'b0, 2'b11, 4'd1, 16'h0000);
        chk("ro_rd", data_out, 16'hA5A5);
        acc(1'b0, 1'b1, 2'b11, 4'd1, 16'hFFFF);
        chk("ro_wr_drop", slot(values_out, 1), 16'h0000);
        values_in[1*16 +: 16] = 16'h5A5A;
        acc(1'b1, 1'b0, 2'b11, 4'd1, 16'h0000);
        chk("ro_rd2", data_out, 16'h5A5A);
        values_in = '0;

        // Out-of-range addresses
        acc(1'b1, 1'b0, 2'b11, 4'd15, 16'h0000);
        chk("oor_rd_ack", {15'd0, ack}, 16'h0001);
        chk("oor_rd_data", data_out, 16'h0000);
        acc(1'b0, 1'b1, 2'b11, 4'd15, 16'hFFFF);
        chk("oor_wr_ack", {15'd0, ack}, 16'h0001);
        acc(1'b0, 1'b1, 2'b11, 4'd11, 16'h0000);
        chk("oor_alias_slot3", slot(values_out, 3), SHADOW ? 16'h0000 : 16'hBE34);
        chk("oor_slot7", slot(values_out, 7), 16'h0000);
        acc(1'b1, 1'b0, 2'b11, 4'd3, 16'h0000);
        chk("oor_rd3", data_out, 16'hBE34);

        // rd+wr together is a read only
        acc(1'b1, 1'b1, 2'b11, 4'd3, 16'h0000);
        chk("rdwr_data", data_out, 16'hBE34);
        acc(1'b1, 1'b0, 2'b11, 4'd3, 16'h0000);
        chk("rdwr_nowrite", data_out, 16'hBE34);

        // Register 6 is in both masks and behaves as RW
        acc(1'b0, 1'b1, 2'b11, 4'd6, 16'h1234);
        acc(1'b1, 1'b0, 2'b11, 4'd6, 16'h0000);
        chk("both_mask_rw", data_out, 16'h1234);

        // Back-to-back write then read of register 2
        en = 1'b1; rd = 1'b0; wr = 1'b1; be = 2'b11; addr = 4'd2; data_in = 16'h5555;
        tick();
        chk("b2b_ack1", {15'd0, ack}, 16'h0001);
        rd = 1'b1; wr = 1'b0;
        tick();
        en = 1'b0; rd = 1'b0;
        chk("b2b_ack2", {15'd0, ack}, 16'h0001);
        chk("b2b_data", data_out, 16'h5555);
        tick();
        chk("b2b_ack_low", {15'd0, ack}, 16'h0000);

        // Shadow commit behaviour (update ignored without shadowing)
        acc(1'b0, 1'b1, 2'b11, 4'd2, 16'h00AA);
        chk("shd_pre_update", slot(values_out, 2), SHADOW ? 16'h0000 : 16'h00AA);
        update = 1'b1;
        tick();
        update = 1'b0;
        chk("shd_post_update", slot(values_out, 2), 16'h00AA);
        chk("shd_slot3", slot(values_out, 3), 16'hBE34);
        update = 1'b1;
        acc(1'b0, 1'b1, 2'b11, 4'd2, 16'h0077);
        update = 1'b0;
        chk("shd_wr_with_update", slot(values_out, 2), 16'h0077);

        // Reset during the ack cycle of a read
        acc(1'b1, 1'b0, 2'b11, 4'd3, 16'h0000);
        chk("pre_rst_data", data_out, 16'hBE34);
        reset = 1'b1;
        #1;
        chk("rst_ack", {15'd0, ack}, 16'h0000);
        chk("rst_dout", data_out, 16'h0000);
        chk("rst_slot2", slot(values_out, 2), 16'h0000);
        chk("rst_slot3", slot(values_out, 3), 16'h0000);
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_no_ack", {15'd0, ack}, 16'h0000);
        end
        acc(1'b1, 1'b0, 2'b11, 4'd3, 16'h0000);
        chk("post_rst_rd3", data_out, 16'h0000);

        // First access right after reset release
        reset = 1'b1;
        tick();
        reset = 1'b0;
        acc(1'b0, 1'b1, 2'b11, 4'd3, 16'h0F0F);
        chk("first_acc_ack", {15'd0, ack}, 16'h0001);
        acc(1'b1, 1'b0, 2'b11, 4'd3, 16'h0000);
        chk("first_acc_rd", data_out, 16'h0F0F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
